// File: rtl/exc_pkg.sv
// exc_pkg -- shared definitions for the exception commit block.
//   * MIPS ExcCode values emitted on exc_code
//   * bit positions of the synchronous request vector exc_req_m
//   * commit FSM state encoding
//   * default exception entry vector
//   * resolve(): priority encoder that selects the winning exception source
package exc_pkg;

  // ExcCode values written to Cause.ExcCode
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Bit positions inside exc_req_m
  localparam int SRC_RI      = 0;
  localparam int SRC_SYS     = 1;
  localparam int SRC_BP      = 2;
  localparam int SRC_OV      = 3;
  localparam int SRC_ADEL_LD = 4;
  localparam int SRC_ADES    = 5;
  localparam int SRC_ERET    = 6;
  localparam int NUM_SRC     = 7;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  // Outcome of the priority resolution for one MEM-stage instruction
  typedef struct packed {
    logic        hit;      // some source (exception or ERET) is active
    logic        is_eret;  // winner is ERET rather than an exception
    logic [4:0]  code;     // ExcCode of the winner (0 when ERET)
    logic        bva_we;   // winner loads BadVAddr
    logic [31:0] bva;      // BadVAddr value
  } resolve_t;

  // Priority: Int > AdEL-fetch > RI > SYS > BP > OV > AdEL-load > AdES > ERET.
  // ERET is therefore only honoured when nothing else is pending, and a
  // misaligned ERET naturally turns into an AdEL-fetch.
  function automatic resolve_t resolve(
    input logic                int_pend,
    input logic                pc_misaligned,
    input logic [NUM_SRC-1:0]  req,
    input logic [31:0]         pc,
    input logic [31:0]         addr
  );
    resolve_t r;
    r     = '0;
    r.hit = 1'b1;
    if (int_pend) begin
      r.code = EXC_INT;
    end else if (pc_misaligned) begin
      r.code   = EXC_ADEL;
      r.bva_we = 1'b1;
      r.bva    = pc;
    end else if (req[SRC_RI]) begin
      r.code = EXC_RI;
    end else if (req[SRC_SYS]) begin
      r.code = EXC_SYS;
    end else if (req[SRC_BP]) begin
      r.code = EXC_BP;
    end else if (req[SRC_OV]) begin
      r.code = EXC_OV;
    end else if (req[SRC_ADEL_LD]) begin
      r.code   = EXC_ADEL;
      r.bva_we = 1'b1;
      r.bva    = addr;
    end else if (req[SRC_ADES]) begin
      r.code   = EXC_ADES;
      r.bva_we = 1'b1;
      r.bva    = addr;
    end else if (req[SRC_ERET]) begin
      r.is_eret = 1'b1;
    end else begin
      r.hit = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/int_sync.sv
// int_sync -- two-flop synchronizer for a bundle of asynchronous level
// signals (hardware interrupt lines). Each bit is synchronized independently;
// interrupt lines are levels, so no multi-bit coherency is needed.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, clears both flop stages
//   async_in : asynchronous inputs
//   sync_out : synchronized outputs, two cycles of latency
module int_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
    end
  end

  assign sync_out = sync_reg;

endmodule

// File: rtl/exc_commit.sv
// exc_commit -- exception / ERET commit unit at the MEM stage.
// Synchronizes the hardware interrupt lines, resolves the highest-priority
// exception source of the MEM instruction, and drives a registered commit
// handshake to CP0 plus a pipeline flush / fetch redirect.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   valid_m,stall_m : MEM instruction valid / MEM stalled (no commit)
//   pc_m, in_ds_m   : MEM PC and branch-delay-slot flag
//   exc_req_m[6:0]  : RI, SYS, BP, OV, AdEL-load, AdES, ERET requests
//   addr_m          : data address of the MEM load/store
//   hw_int          : asynchronous hardware interrupt lines
//   cp0_status      : Status (IM=[15:8], EXL=[1], IE=[0])
//   cp0_cause_ip    : software interrupt bits Cause.IP[1:0]
//   cp0_epc         : current EPC, target of ERET
//   ip_sync         : synchronized interrupt lines for Cause.IP[7:2]
//   exc_valid       : one-cycle exception commit pulse
//   exc_code, exc_epc, exc_bd : Cause.ExcCode, EPC, Cause.BD to write
//   badvaddr_we, badvaddr     : BadVAddr write enable / value
//   eret_valid      : one-cycle ERET commit pulse
//   flush, new_pc   : pipeline flush and redirect target
//   busy            : FSM not idle
module exc_commit
  import exc_pkg::*;
#(
  parameter int          NUM_HW_INT   = 6,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_m,
  input  logic                  stall_m,
  input  logic [31:0]           pc_m,
  input  logic                  in_ds_m,
  input  logic [NUM_SRC-1:0]    exc_req_m,
  input  logic [31:0]           addr_m,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic [31:0]           cp0_status,
  input  logic [1:0]            cp0_cause_ip,
  input  logic [31:0]           cp0_epc,
  output logic [NUM_HW_INT-1:0] ip_sync,
  output logic                  exc_valid,
  output logic [4:0]            exc_code,
  output logic [31:0]           exc_epc,
  output logic                  exc_bd,
  output logic                  badvaddr_we,
  output logic [31:0]           badvaddr,
  output logic                  eret_valid,
  output logic                  flush,
  output logic [31:0]           new_pc,
  output logic                  busy
);

  // Remaining FLUSH-state cycles after COMMIT; COMMIT itself is the first
  // flush cycle, so FLUSH lasts FLUSH_CYCLES-1 cycles.
  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  state_t      state_reg;
  logic [3:0]  flush_cnt_reg;

  logic        exc_valid_reg;
  logic        eret_valid_reg;
  logic [4:0]  exc_code_reg;
  logic [31:0] exc_epc_reg;
  logic        exc_bd_reg;
  logic        badvaddr_we_reg;
  logic [31:0] badvaddr_reg;
  logic        flush_reg;
  logic [31:0] new_pc_reg;

  logic [7:0]  ip_all;
  logic        int_pend;
  logic        pc_misaligned;
  logic        accept;
  logic [31:0] epc_next;
  resolve_t    res;

  // Interrupt synchronizer
  int_sync #(
    .WIDTH (NUM_HW_INT)
  ) u_int_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (hw_int),
    .sync_out (ip_sync)
  );

  // Cause.IP[7:0] view; lines above NUM_HW_INT+1 read as zero.
  always_comb begin
    ip_all                   = '0;
    ip_all[NUM_HW_INT+1:0]   = {ip_sync, cp0_cause_ip};
  end

  assign int_pend      = (|(ip_all & cp0_status[15:8])) && !cp0_status[1] && cp0_status[0];
  assign pc_misaligned = (pc_m[1:0] != 2'b00);
  assign accept        = (state_reg == ST_IDLE) && valid_m && !stall_m;
  // Delay-slot instructions restart at the branch, one word earlier.
  assign epc_next      = in_ds_m ? (pc_m - 32'd4) : pc_m;
  assign res           = resolve(int_pend, pc_misaligned, exc_req_m, pc_m, addr_m);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      flush_cnt_reg   <= '0;
      exc_valid_reg   <= 1'b0;
      eret_valid_reg  <= 1'b0;
      exc_code_reg    <= '0;
      exc_epc_reg     <= '0;
      exc_bd_reg      <= 1'b0;
      badvaddr_we_reg <= 1'b0;
      badvaddr_reg    <= '0;
      flush_reg       <= 1'b0;
      new_pc_reg      <= '0;
    end else begin
      // Commit strobes are only ever high for the single COMMIT cycle.
      exc_valid_reg   <= 1'b0;
      eret_valid_reg  <= 1'b0;
      badvaddr_we_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept && res.hit) begin
            state_reg       <= ST_COMMIT;
            exc_valid_reg   <= !res.is_eret;
            eret_valid_reg  <= res.is_eret;
            exc_code_reg    <= res.code;
            exc_epc_reg     <= epc_next;
            exc_bd_reg      <= in_ds_m;
            badvaddr_we_reg <= res.bva_we;
            badvaddr_reg    <= res.bva;
            flush_reg       <= 1'b1;
            // ERET target is captured now so later CP0 writes cannot move it.
            new_pc_reg      <= res.is_eret ? cp0_epc : EXC_VECTOR;
          end
        end
        ST_COMMIT: begin
          if (FLUSH_CYCLES == 1) begin
            state_reg <= ST_IDLE;
            flush_reg <= 1'b0;
          end else begin
            state_reg     <= ST_FLUSH;
            flush_cnt_reg <= FLUSH_LOAD;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_reg == 4'd0) begin
            state_reg <= ST_IDLE;
            flush_reg <= 1'b0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          flush_reg <= 1'b0;
        end
      endcase
    end
  end

  assign exc_valid   = exc_valid_reg;
  assign eret_valid  = eret_valid_reg;
  assign exc_code    = exc_code_reg;
  assign exc_epc     = exc_epc_reg;
  assign exc_bd      = exc_bd_reg;
  assign badvaddr_we = badvaddr_we_reg;
  assign badvaddr    = badvaddr_reg;
  assign flush       = flush_reg;
  assign new_pc      = new_pc_reg;
  assign busy        = (state_reg != ST_IDLE);

  // Status bits outside IM/EXL/IE are not relevant to interrupt masking.
  logic unused_status;
  assign unused_status = &{1'b0, cp0_status[31:16], cp0_status[7:2]};

endmodule

// File: tb/tb_exc_commit.sv
// tb_exc_commit -- directed plus randomized check of exc_commit against a
// behavioural model of the exception priority / EPC / redirect rules.
module tb_exc_commit;

  localparam int          NHW = 6;
  localparam int          FC  = 3;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_m;
  logic           stall_m;
  logic [31:0]    pc_m;
  logic           in_ds_m;
  logic [6:0]     exc_req_m;
  logic [31:0]    addr_m;
  logic [NHW-1:0] hw_int;
  logic [31:0]    cp0_status;
  logic [1:0]     cp0_cause_ip;
  logic [31:0]    cp0_epc;
  logic [NHW-1:0] ip_sync;
  logic           exc_valid;
  logic [4:0]     exc_code;
  logic [31:0]    exc_epc;
  logic           exc_bd;
  logic           badvaddr_we;
  logic [31:0]    badvaddr;
  logic           eret_valid;
  logic           flush;
  logic [31:0]    new_pc;
  logic           busy;

  always #5 clk = ~clk;

  exc_commit #(
    .NUM_HW_INT   (NHW),
    .FLUSH_CYCLES (FC),
    .EXC_VECTOR   (VEC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_m      (valid_m),
    .stall_m      (stall_m),
    .pc_m         (pc_m),
    .in_ds_m      (in_ds_m),
    .exc_req_m    (exc_req_m),
    .addr_m       (addr_m),
    .hw_int       (hw_int),
    .cp0_status   (cp0_status),
    .cp0_cause_ip (cp0_cause_ip),
    .cp0_epc      (cp0_epc),
    .ip_sync      (ip_sync),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_epc      (exc_epc),
    .exc_bd       (exc_bd),
    .badvaddr_we  (badvaddr_we),
    .badvaddr     (badvaddr),
    .eret_valid   (eret_valid),
    .flush        (flush),
    .new_pc       (new_pc),
    .busy         (busy)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        ev;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        we;
    logic [31:0] bva;
    logic [31:0] npc;
  } exp_t;

  // Environment the model sees; hw is held stable long enough to be synchronized.
  logic [NHW-1:0] env_hw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected architectural outcome of presenting one instruction in MEM.
  function automatic exp_t model(input logic [31:0] pc, input logic ds, input logic [6:0] req,
                                 input logic [31:0] addr, input logic [NHW-1:0] hw,
                                 input logic [31:0] st, input logic [1:0] cip, input logic [31:0] epc);
    exp_t e;
    logic [7:0] masked;
    e      = '0;
    masked = {hw, cip} & st[15:8];
    e.ev   = 1'b1;
    e.epc  = ds ? pc - 32'd4 : pc;
    e.bd   = ds;
    e.npc  = VEC;
    if (masked != 8'd0 && !st[1] && st[0]) e.code = 5'd0;
    else if (pc[1:0] != 2'b00) begin e.code = 5'd4; e.we = 1'b1; e.bva = pc; end
    else if (req[0]) e.code = 5'd10;
    else if (req[1]) e.code = 5'd8;
    else if (req[2]) e.code = 5'd9;
    else if (req[3]) e.code = 5'd12;
    else if (req[4]) begin e.code = 5'd4; e.we = 1'b1; e.bva = addr; end
    else if (req[5]) begin e.code = 5'd5; e.we = 1'b1; e.bva = addr; end
    else if (req[6]) begin e.eret = 1'b1; e.npc = epc; end
    else e.ev = 1'b0;
    return e;
  endfunction

  task automatic set_env(input logic [NHW-1:0] hw, input logic [31:0] st, input logic [1:0] cip);
    valid_m      = 1'b0;
    hw_int       = hw;
    env_hw       = hw;
    cp0_status   = st;
    cp0_cause_ip = cip;
    repeat (3) step();
  endtask

  // Check the cycle right after a request was presented.
  task automatic check_commit(input string tag, input exp_t e);
    if (e.ev) begin
      chk({tag, ".exc_valid"}, 32'(exc_valid), 32'(!e.eret));
      chk({tag, ".eret_valid"}, 32'(eret_valid), 32'(e.eret));
      if (!e.eret) begin
        chk({tag, ".code"}, 32'(exc_code), 32'(e.code));
        chk({tag, ".epc"}, exc_epc, e.epc);
        chk({tag, ".bd"}, 32'(exc_bd), 32'(e.bd));
      end
      chk({tag, ".bva_we"}, 32'(badvaddr_we), 32'(e.we));
      if (e.we) chk({tag, ".bva"}, badvaddr, e.bva);
      chk({tag, ".new_pc"}, new_pc, e.npc);
      chk({tag, ".flush"}, 32'(flush), 32'd1);
      chk({tag, ".busy"}, 32'(busy), 32'd1);
    end else begin
      chk({tag, ".no_pulse"}, 32'({exc_valid, eret_valid}), 32'd0);
      chk({tag, ".idle"}, 32'({busy, flush}), 32'd0);
    end
  endtask

  // Count flush-high cycles (commit cycle already seen) and ensure quiet strobes.
  task automatic drain(input string tag);
    int n;
    int guard;
    n     = 1;
    guard = 0;
    step();
    while (flush === 1'b1 && guard < 20) begin
      n++;
      guard++;
      chk({tag, ".quiet"}, 32'({exc_valid, eret_valid}), 32'd0);
      step();
    end
    chk({tag, ".flush_len"}, 32'(n), 32'(FC));
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic txn(input string tag, input logic [31:0] pc, input logic ds, input logic [6:0] req,
                     input logic [31:0] addr, input logic [31:0] epc, input logic stall);
    exp_t e;
    pc_m      = pc;
    in_ds_m   = ds;
    exc_req_m = req;
    addr_m    = addr;
    cp0_epc   = epc;
    stall_m   = stall;
    valid_m   = 1'b1;
    e = model(pc, ds, req, addr, env_hw, cp0_status, cp0_cause_ip, epc);
    if (stall) e.ev = 1'b0;
    step();
    valid_m   = 1'b0;
    stall_m   = 1'b0;
    exc_req_m = '0;
    cp0_epc   = ~epc;  // target must have been captured at acceptance
    check_commit(tag, e);
    $display("[TB] %s pc=%h req=%b ds=%b -> code=%0d epc=%h eret=%b", tag, pc, req, ds, exc_code, exc_epc, eret_valid);
    if (e.ev) drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b1; valid_m = 1'b0; stall_m = 1'b0; pc_m = '0; in_ds_m = 1'b0; exc_req_m = '0;
    addr_m = '0; hw_int = '0; env_hw = '0; cp0_status = '0; cp0_cause_ip = '0; cp0_epc = '0;
    step(); step();
    chk("rst.strobes", 32'({exc_valid, eret_valid, badvaddr_we}), 32'd0);
    chk("rst.flush_busy", 32'({flush, busy}), 32'd0);
    chk("rst.code", 32'(exc_code), 32'd0);
    chk("rst.epc", exc_epc, 32'd0);
    chk("rst.new_pc", new_pc, 32'd0);
    chk("rst.bva", badvaddr, 32'd0);
    chk("rst.ip_sync", 32'(ip_sync), 32'd0);
    rst = 1'b0;
    set_env('0, 32'h0, 2'b00);

    // Overflow, aligned, not in a delay slot
    txn("ov", 32'h80001000, 1'b0, 7'b0001000, 32'h0, 32'h0, 1'b0);
    // AdES in a delay slot
    txn("ades_ds", 32'h80000010, 1'b1, 7'b0100000, 32'h80002003, 32'h0, 1'b0);
    // Nothing requested, and a stalled request
    txn("none", 32'h80000040, 1'b0, 7'b0000000, 32'h0, 32'h0, 1'b0);
    txn("stalled", 32'h80000044, 1'b0, 7'b0000010, 32'h0, 32'h0, 1'b1);
    // ERET alone and ERET from a misaligned PC
    txn("eret", 32'h80000300, 1'b0, 7'b1000000, 32'h0, 32'h80000200, 1'b0);
    txn("eret_mis", 32'h80000202, 1'b0, 7'b1000000, 32'h0, 32'h80000200, 1'b0);

    // Interrupt arriving together with SYS while MEM is stalled
    set_env('0, 32'h00000401, 2'b00);
    hw_int = 6'b000001; env_hw = 6'b000001;
    pc_m = 32'h80000100; in_ds_m = 1'b0; exc_req_m = 7'b0000010; valid_m = 1'b1; stall_m = 1'b1;
    step();
    chk("int.ip_sync_1cyc", 32'(ip_sync[0]), 32'd0);
    step();
    chk("int.ip_sync_2cyc", 32'(ip_sync[0]), 32'd1);
    chk("int.stalled_quiet", 32'({exc_valid, busy}), 32'd0);
    stall_m = 1'b0;
    e = model(pc_m, 1'b0, exc_req_m, 32'h0, env_hw, cp0_status, cp0_cause_ip, 32'h0);
    step();
    valid_m = 1'b0; exc_req_m = '0;
    check_commit("int_sys", e);
    chk("int_sys.code_is_int", 32'(exc_code), 32'd0);
    $display("[TB] int_sys -> code=%0d epc=%h", exc_code, exc_epc);
    drain("int_sys");
    set_env('0, 32'h0, 2'b00);

    // Second request while busy must wait until IDLE
    pc_m = 32'h80000500; in_ds_m = 1'b0; exc_req_m = 7'b0000001; addr_m = '0; valid_m = 1'b1;
    e = model(pc_m, 1'b0, exc_req_m, 32'h0, env_hw, cp0_status, cp0_cause_ip, 32'h0);
    step();
    check_commit("busy_first", e);
    pc_m = 32'h80000600; in_ds_m = 1'b1; exc_req_m = 7'b0000100;
    e = model(pc_m, 1'b1, exc_req_m, 32'h0, env_hw, cp0_status, cp0_cause_ip, 32'h0);
    drain("busy_first");
    chk("busy_second.not_yet", 32'({exc_valid, eret_valid}), 32'd0);
    step();
    valid_m = 1'b0; exc_req_m = '0;
    check_commit("busy_second", e);
    $display("[TB] busy_second -> code=%0d epc=%h bd=%b", exc_code, exc_epc, exc_bd);
    drain("busy_second");

    // Reset while in FLUSH
    pc_m = 32'h80000700; in_ds_m = 1'b0; exc_req_m = 7'b0001000; valid_m = 1'b1;
    step();
    valid_m = 1'b0; exc_req_m = '0;
    chk("rstflush.commit", 32'(exc_valid), 32'd1);
    step();
    chk("rstflush.in_flush", 32'({busy, flush}), 32'b11);
    rst = 1'b1;
    step();
    chk("rstflush.cleared", 32'({busy, flush, exc_valid, eret_valid}), 32'd0);
    chk("rstflush.code", 32'(exc_code), 32'd0);
    rst = 1'b0;
    step();
    chk("rstflush.after", 32'({busy, flush, exc_valid, eret_valid}), 32'd0);
    $display("[TB] reset in FLUSH -> busy=%b flush=%b", busy, flush);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [NHW-1:0] hw;
      logic [31:0]    st;
      logic [1:0]     cip;
      logic [31:0]    pc;
      logic [6:0]     req;
      logic           stall;
      hw  = ($urandom_range(0, 3) == 0) ? NHW'($urandom) : '0;
      cip = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      st  = {16'h0, 8'($urandom), 6'h0, ($urandom_range(0, 3) == 0), 1'($urandom)};
      set_env(hw, st, cip);
      chk("rnd.ip_sync", 32'(ip_sync), 32'(hw));
      pc = $urandom;
      pc[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      case ($urandom_range(0, 3))
        0:       req = 7'd0;
        1:       req = 7'($urandom);
        default: req = 7'(1 << $urandom_range(0, 6));
      endcase
      stall = ($urandom_range(0, 7) == 0);
      txn("rnd", pc, 1'($urandom), req, $urandom, $urandom, stall);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/exc_commit.md
EXC_COMMIT -- requirements
Module: exc_commit

Interface
REQ-001 SHALL take parameter NUM_HW_INT, default 6: number of hardware interrupt lines, range 1..6.
REQ-002 SHALL take parameter FLUSH_CYCLES, default 1: cycles flush stays asserted per taken event, range 1..15.
REQ-003 SHALL take parameter EXC_VECTOR, default 32'hBFC00380: exception entry PC.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  reset: synchronous, active-high.
REQ-006 SHALL have port valid_m  in  1  MEM-stage instruction valid.
REQ-007 SHALL have port stall_m  in  1  MEM stage stalled; no commit while high.
REQ-008 SHALL have port pc_m  in  32  MEM-stage PC.
REQ-009 SHALL have port in_ds_m  in  1  MEM instruction sits in a branch delay slot.
REQ-010 SHALL have port exc_req_m  in  7  source bits: [0] RI, [1] SYS, [2] BP, [3] OV, [4] AdEL-load, [5] AdES, [6] ERET.
REQ-011 SHALL have port addr_m  in  32  data address of the MEM load/store.
REQ-012 SHALL have port hw_int  in  NUM_HW_INT  asynchronous interrupt lines.
REQ-013 SHALL have port cp0_status  in  32  Status (IM=[15:8], EXL=[1], IE=[0]).
REQ-014 SHALL have port cp0_cause_ip  in  2  software IP[1:0] from Cause.
REQ-015 SHALL have port cp0_epc  in  32  current EPC, the ERET target.
REQ-016 SHALL have port ip_sync  out  NUM_HW_INT  synchronized interrupt lines to CP0 Cause.IP[7:2].
REQ-017 SHALL have port exc_valid  out  1  one-cycle pulse: exception committed, CP0 SHALL update.
REQ-018 SHALL have port exc_code  out  5  ExcCode.
REQ-019 SHALL have port exc_epc  out  32  EPC value to write.
REQ-020 SHALL have port exc_bd  out  1  Cause.BD value.
REQ-021 SHALL have port badvaddr_we  out  1  BadVAddr write enable, valid with exc_valid.
REQ-022 SHALL have port badvaddr  out  32  BadVAddr value.
REQ-023 SHALL have port eret_valid  out  1  one-cycle pulse: ERET committed, CP0 SHALL clear EXL.
REQ-024 SHALL have port flush  out  1  flush IF..MEM and redirect fetch.
REQ-025 SHALL have port new_pc  out  32  redirect target, valid while flush=1.
REQ-026 SHALL have port busy  out  1  state != IDLE.

Function
REQ-027 SHALL pass hw_int through two flops per bit to form ip_sync; 2-cycle latency.
REQ-028 SHALL detect interrupt int_pend when (({ip_sync, cp0_cause_ip} & IM[NUM_HW_INT+1:0]) != 0) && !EXL && IE, using zero extension when NUM_HW_INT<6.
REQ-029 SHALL evaluate the event only when state==IDLE && valid_m && !stall_m; it SHALL ignore all requests otherwise.
REQ-030 SHALL resolve the highest-priority source in this order: Int(0) > AdEL-fetch, pc_m[1:0]!=0 (4) > RI(10) > SYS(8) > BP(9) > OV(12) > AdEL-load(4) > AdES(5) > ERET.
REQ-031 SHALL set badvaddr to pc_m for AdEL-fetch, to addr_m for AdEL-load/AdES, and to 0 with badvaddr_we=0 for all other sources.
REQ-032 SHALL set exc_epc=pc_m-4 and exc_bd=1 when in_ds_m=1, else exc_epc=pc_m and exc_bd=0; subtraction SHALL wrap modulo 2^32.
REQ-033 SHALL use FSM states IDLE, COMMIT, FLUSH.
REQ-034 SHALL go IDLE->COMMIT on an accepted event, registering code, epc, bd, badvaddr, target and the is_eret flag.
REQ-035 SHALL hold COMMIT one cycle: exc_valid=1, or eret_valid=1 for ERET, with flush=1.
REQ-036 SHALL go COMMIT->IDLE when FLUSH_CYCLES==1, else COMMIT->FLUSH.
REQ-037 SHALL keep flush=1 in FLUSH and return to IDLE after FLUSH_CYCLES-1 cycles, for exactly FLUSH_CYCLES total flush cycles.
REQ-038 SHALL set new_pc=EXC_VECTOR for exceptions and cp0_epc for ERET; the ERET target SHALL be sampled at acceptance.
REQ-039 SHALL treat simultaneous interrupt and synchronous source as Int, with EPC of the MEM instruction, which is not committed.
REQ-040 SHALL apply ERET only when no other source is set; a misaligned-PC ERET SHALL take AdEL.
REQ-041 SHALL keep exc_valid and eret_valid mutually exclusive and never high outside COMMIT.

Reset
REQ-042 SHALL on rst force state IDLE, all outputs 0, synchronizer flops 0 and the flush counter 0, including mid-COMMIT/FLUSH; no pulse SHALL follow reset.

Structure
REQ-043 SHALL place ExcCode constants, source bit indices, the state encoding and the default EXC_VECTOR in package exc_pkg.
REQ-044 SHALL place the synchronizer in sub-module int_sync, parameterised by width and instanced once.

Verification
REQ-045 SHALL cover: exc_req_m=7'b0001000 (OV), pc_m=32'h80001000, in_ds_m=0 -> next cycle exc_valid=1, exc_code=12, exc_epc=32'h80001000, flush=1, new_pc=32'hBFC00380.
REQ-046 SHALL cover: AdES, addr_m=32'h80002003, pc_m=32'h80000010, in_ds_m=1 -> exc_code=5, exc_epc=32'h8000000C, exc_bd=1, badvaddr_we=1, badvaddr=32'h80002003.
REQ-047 SHALL cover: Status=32'h00000401, hw_int[0] rises together with SYS request -> 2 cycles later exc_code=0 (not 8), ip_sync[0]=1.
REQ-048 SHALL cover: ERET alone, cp0_epc=32'h80000200 -> eret_valid=1, exc_valid=0, new_pc=32'h80000200; ERET with pc_m=32'h80000202 -> exc_code=4, badvaddr=32'h80000202.
REQ-049 SHALL cover: FLUSH_CYCLES=3 with a second request arriving while busy -> flush high exactly 3 cycles, second request ignored until IDLE.
REQ-050 SHALL cover: rst asserted in FLUSH -> next cycle busy=0, flush=0, no exc_valid pulse.
